// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, bout = borrow-out.
// One full-subtractor cell with a registered borrow handles one bit per clock, LSB first.
`timescale 1ns/1ps
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             borrow;
  logic [CW-1:0]    count;

  logic             ai;
  logic             bi;
  logic             d;
  logic             borrow_next;
  logic [WIDTH-1:0] r_next;
  logic             accept;

  // Full-subtractor cell on the current LSBs and the registered borrow
  always_comb begin
    ai          = a_sr[0];
    bi          = b_sr[0];
    d           = ai ^ bi ^ borrow;
    borrow_next = (~ai & bi) | (~ai & borrow) | (bi & borrow);
    r_next      = {d, r_sr[WIDTH-1:1]};
    accept      = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            r_sr   <= '0;
            borrow <= bin;
            count  <= '0;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= r_next;
          borrow <= borrow_next;
          count  <= count + 1'b1;
          // Result registers only move on the final bit so partial sums never show
          if (count == LAST) begin
            diff  <= r_next;
            bout  <= borrow_next;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8.
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; observe and drive 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b diff=%h bout=%b required 0 0 00 0", busy, done, diff, bout);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_rst_start();
    rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h01; bin = 1'b0;
    step();
    rst = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_start: busy=%b done=%b required 0 0", busy, done);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_after: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic();
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0; a = 8'hFF; b = 8'h00; bin = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b required 1 0", c, busy, done);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'h37 || bout !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b diff=%h bout=%b required 1 0 37 0", done, busy, diff, bout);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h37) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b diff=%h required 0 0 37", done, busy, diff);
    end
  endtask

  task automatic test_borrow();
    logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h10, 8'hC3};
    logic [7:0] vb [4] = '{8'h01, 8'hFF, 8'h10, 8'h3C};
    logic       vi [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ed [4] = '{8'hFF, 8'hFF, 8'h00, 8'h86};
    logic       eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int n;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; bin = vi[i]; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (n != 8 || diff !== ed[i] || bout !== eb[i]) begin
        errors++;
        $display("FAIL borrow vec %0d: cycles=%0d diff=%h bout=%b required 8 %h %b", i, n, diff, bout, ed[i], eb[i]);
      end
      step();
    end
  endtask

  task automatic test_ignored_start();
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    a = 8'h01; b = 8'h02; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'h86) begin
        errors++;
        $display("FAIL ignored_busy cycle %0d: busy=%b done=%b diff=%h required 1 0 86", c, busy, done, diff);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || diff !== 8'h37 || bout !== 1'b0) begin
      errors++;
      $display("FAIL ignored_done: done=%b diff=%h bout=%b required 1 37 0", done, diff, bout);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignored_after: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b diff=%h bout=%b required 0 0 00 0", busy, done, diff, bout);
    end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet cycle %0d: done=%b busy=%b required 0 0", c, done, busy);
      end
      step();
    end
    a = 8'hC3; b = 8'h3C; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != 8 || diff !== 8'h86 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fresh: cycles=%0d diff=%h bout=%b required 8 86 0", n, diff, bout);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != 8 || diff !== 8'h37) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d diff=%h required 8 37", n, diff);
    end
    a = 8'h80; b = 8'h7F; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'h37 || bout !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold cycle %0d: busy=%b done=%b diff=%h bout=%b required 1 0 37 0", c, busy, done, diff, bout);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || diff !== 8'h01 || bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: done=%b diff=%h bout=%b required 1 01 0", done, diff, bout);
    end
    step();
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    logic       ri;
    logic [8:0] exp_v;
    int n;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); ri = 1'($urandom);
      exp_v = {1'b0, ra} - {1'b0, rb} - {8'h00, ri};
      a = ra; b = rb; bin = ri; start = 1'b1;
      step();
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (n != 8 || {bout, diff} !== exp_v) begin
        errors++;
        $display("FAIL random %0d a=%h b=%h bin=%b: cycles=%0d got %h required 8 %h", i, ra, rb, ri, n, {bout, diff}, exp_v);
      end
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rst_start();
    test_basic();
    test_borrow();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
